// File: rtl/sign_narrow_pkg.sv
// Shared definitions for the 32->16 narrowing datapath: mode encodings,
// saturation limits, FIFO entry layout and range-check helpers.
package sign_narrow_pkg;

    typedef enum logic [1:0] {
        NARROW_WRAP    = 2'b00,
        NARROW_SAT_S   = 2'b01,
        NARROW_SAT_U   = 2'b10,
        NARROW_ILLEGAL = 2'b11
    } narrow_mode_e;

    localparam logic [15:0] SAT_S_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_S_MIN = 16'h8000;
    localparam logic [15:0] SAT_U_MAX = 16'hFFFF;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
    } narrow_entry_t;

    // Word is representable as a signed halfword: bits 31..15 all equal.
    function automatic logic fits_signed16(input logic [31:0] word);
        return (&word[31:15]) | ~(|word[31:15]);
    endfunction

    // Word is representable as an unsigned halfword: upper half is zero.
    function automatic logic fits_unsigned16(input logic [31:0] word);
        return ~(|word[31:16]);
    endfunction

endpackage

// File: rtl/sign_narrow_core.sv
// Purely combinational narrowing of a 32-bit word to 16 bits under the
// selected wrap / saturate policy, with a lossiness flag.
module narrow_core
    import sign_narrow_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  mode_i,
    output logic [15:0] data,
    output logic        ovf
);

    logic fit_s;
    logic fit_u;

    assign fit_s = fits_signed16(data_i);
    assign fit_u = fits_unsigned16(data_i);

    always_comb begin
        data = data_i[15:0];
        ovf  = 1'b0;
        case (narrow_mode_e'(mode_i))
            NARROW_WRAP: begin
                data = data_i[15:0];
                ovf  = ~fit_s;
            end
            NARROW_SAT_S: begin
                if (fit_s) begin
                    data = data_i[15:0];
                    ovf  = 1'b0;
                end else begin
                    data = data_i[31] ? SAT_S_MIN : SAT_S_MAX;
                    ovf  = 1'b1;
                end
            end
            NARROW_SAT_U: begin
                // Negative inputs clamp to zero before the magnitude check.
                if (data_i[31]) begin
                    data = 16'h0000;
                    ovf  = 1'b1;
                end else if (!fit_u) begin
                    data = SAT_U_MAX;
                    ovf  = 1'b1;
                end else begin
                    data = data_i[15:0];
                    ovf  = 1'b0;
                end
            end
            NARROW_ILLEGAL: begin
                data = data_i[15:0];
                ovf  = 1'b1;
            end
            default: begin
                data = data_i[15:0];
                ovf  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrowing stage with valid/ready input, small output FIFO and a
// saturating debug counter of lossy conversions.
module sign_narrow
    import sign_narrow_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [15:0]      data_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [15:0]       core_data;
    logic              core_ovf;

    narrow_entry_t     mem [DEPTH];
    narrow_entry_t     head;
    narrow_entry_t     last_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [PTR_W:0]    count_next;
    logic [CNT_W-1:0]  ovf_cnt_reg;
    logic              push;
    logic              pop;

    narrow_core u_core (
        .data_i (data_i),
        .mode_i (mode_i),
        .data   (core_data),
        .ovf    (core_ovf)
    );

    // Acceptance depends only on registered occupancy, never on ready_i.
    assign ready_o   = rst_i && (count_reg < FULL_COUNT);
    assign valid_o   = (count_reg != '0);
    assign push      = valid_i && ready_o;
    assign pop       = valid_o && ready_i;
    assign head      = mem[rd_ptr_reg];
    assign data_o    = valid_o ? head.data : last_reg.data;
    assign ovf_o     = valid_o ? head.ovf  : last_reg.ovf;
    assign ovf_cnt_o = ovf_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{data: core_data, ovf: core_ovf};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            last_reg    <= '0;
            ovf_cnt_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            // Keep the popped head so the outputs stay stable once empty.
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                last_reg   <= head;
            end
            if (push && core_ovf && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule
